mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous data/instruction RAM between the CPU instruction-fetch unit and the load/store unit.
- Grants one access at a time, tracks read latency and routes read data back to the owner.
- Data accesses have priority; a starvation guard guarantees fetch progress.
- Sits between the core pipeline and the unified memory inside the top-level CPU.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch
// and the load/store unit. Data accesses win contention, but a starvation
// counter forces a fetch through after STARVE_MAX contested data grants.
// Read data is steered back to whichever port owned the read.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_d_q, owner_d_d;   // 1 = read in flight belongs to data port
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;

  logic        free;
  logic        grant_d;
  logic        grant_if;
  logic        rd_grant;

  // Arbitration, memory strobes and next-state computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_d_d   = owner_d_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;

    // The rvalid cycle of a read is also a free cycle, so reads pipeline.
    free     = (state_q == IDLE) || (cnt_q == 3'(RD_LAT));
    grant_d  = !rst && free && d_req && (!if_req || (starve_q < 4'(STARVE_MAX)));
    grant_if = !rst && free && if_req && !grant_d;
    rd_grant = grant_if || (grant_d && !d_we);

    mem_en    = grant_d || grant_if;
    mem_addr  = grant_d ? d_addr : if_addr;
    mem_wdata = d_wdata;
    mem_we    = (grant_d && d_we) ? d_wstrb : {STRB_W{1'b0}};

    if (rd_grant) begin
      state_d   = RD_WAIT;
      cnt_d     = 3'd1;
      owner_d_d = grant_d;
    end else if (state_q == RD_WAIT && !free) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end

    if (state_d == RD_WAIT && cnt_d == 3'(RD_LAT)) begin
      d_rvalid_d  = owner_d_d;
      if_rvalid_d = !owner_d_d;
    end

    // Fetch losing a contested slot is what counts toward starvation.
    if (!if_req || grant_if) begin
      starve_d = 4'd0;
    end else if (grant_d) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // State, latency counter, owner and registered rvalid flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 4'd0;
      owner_d_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_d_q   <= owner_d_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances with RD_LAT = 1, 2, 3
// share the same stimulus; each scenario checks the instance it targets.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NI = 3;  // instance g has RD_LAT = g+1

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic [DW-1:0] mem_rdata;

  logic          if_gnt_o    [NI];
  logic          if_rvalid_o [NI];
  logic [DW-1:0] if_rdata_o  [NI];
  logic          d_gnt_o     [NI];
  logic          d_rvalid_o  [NI];
  logic [DW-1:0] d_rdata_o   [NI];
  logic          mem_en_o    [NI];
  logic [SW-1:0] mem_we_o    [NI];
  logic [AW-1:0] mem_addr_o  [NI];
  logic [DW-1:0] mem_wdata_o [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .RD_LAT    (g + 1),
      .STARVE_MAX(4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt_o[g]),
      .if_rvalid(if_rvalid_o[g]),
      .if_rdata (if_rdata_o[g]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_wstrb  (d_wstrb),
      .d_gnt    (d_gnt_o[g]),
      .d_rvalid (d_rvalid_o[g]),
      .d_rdata  (d_rdata_o[g]),
      .mem_en   (mem_en_o[g]),
      .mem_we   (mem_we_o[g]),
      .mem_addr (mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]),
      .mem_rdata(mem_rdata)
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_quiet(input int i, input string tag);
    check({tag, ".if_gnt"},    if_gnt_o[i],    1'b0);
    check({tag, ".d_gnt"},     d_gnt_o[i],     1'b0);
    check({tag, ".mem_en"},    mem_en_o[i],    1'b0);
    check({tag, ".mem_we"},    mem_we_o[i],    '0);
    check({tag, ".if_rvalid"}, if_rvalid_o[i], 1'b0);
    check({tag, ".d_rvalid"},  d_rvalid_o[i],  1'b0);
  endtask

  task automatic drop_all();
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wstrb = '0;
  endtask

  task automatic drain(input int n);
    drop_all();
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    if_req    = 1'b1;  // held through reset: must not be granted
    if_addr   = 32'h0000_0010;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_wstrb   = '0;
    mem_rdata = '0;

    // ---- Reset state on all instances ----
    cyc(); cyc(); mid();
    for (int i = 0; i < NI; i++) check_quiet(i, $sformatf("reset[%0d]", i));
    cyc();
    rst = 1'b0;
    drop_all();
    cyc();

    // ---- Single fetch, RD_LAT=1 ----
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    mid();
    check("fetch.if_gnt",   if_gnt_o[0],   1'b1);
    check("fetch.d_gnt",    d_gnt_o[0],    1'b0);
    check("fetch.mem_en",   mem_en_o[0],   1'b1);
    check("fetch.mem_addr", mem_addr_o[0], 32'h0000_0010);
    check("fetch.mem_we",   mem_we_o[0],   4'b0000);
    cyc();
    if_req    = 1'b0;
    mem_rdata = 32'h0010_0093;
    mid();
    check("fetch.if_rvalid", if_rvalid_o[0], 1'b1);
    check("fetch.if_rdata",  if_rdata_o[0],  32'h0010_0093);
    check("fetch.d_rvalid",  d_rvalid_o[0],  1'b0);
    cyc();
    mid();
    check("fetch.if_rvalid_pulse", if_rvalid_o[0], 1'b0);
    drain(5);

    // ---- Byte store with a pending fetch, RD_LAT=1 ----
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0104;
    d_wdata = 32'h0000_00AB;
    d_wstrb = 4'b0001;
    if_req  = 1'b1;
    if_addr = 32'h0000_0020;
    mid();
    check("store.d_gnt",     d_gnt_o[0],     1'b1);
    check("store.if_gnt",    if_gnt_o[0],    1'b0);
    check("store.mem_en",    mem_en_o[0],    1'b1);
    check("store.mem_we",    mem_we_o[0],    4'b0001);
    check("store.mem_addr",  mem_addr_o[0],  32'h0000_0104);
    check("store.mem_wdata", mem_wdata_o[0], 32'h0000_00AB);
    cyc();
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wstrb = '0;
    mid();
    check("store.no_d_rvalid", d_rvalid_o[0], 1'b0);
    check("store.fetch_gnt",   if_gnt_o[0],   1'b1);
    check("store.fetch_addr",  mem_addr_o[0], 32'h0000_0020);
    check("store.fetch_we",    mem_we_o[0],   4'b0000);
    cyc();
    if_req = 1'b0;
    mid();
    check("store.fetch_rvalid", if_rvalid_o[0], 1'b1);
    drain(5);

    // ---- Write with zero strobes still consumes a grant ----
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0108;
    d_wstrb = 4'b0000;
    mid();
    check("zstrb.d_gnt",  d_gnt_o[0],  1'b1);
    check("zstrb.mem_en", mem_en_o[0], 1'b1);
    check("zstrb.mem_we", mem_we_o[0], 4'b0000);
    cyc();
    drop_all();
    mid();
    check("zstrb.no_rvalid", d_rvalid_o[0], 1'b0);
    drain(5);

    // ---- Back-to-back reads, RD_LAT=1 ----
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0200;
    mid();
    check("b2b.gnt0",   d_gnt_o[0],    1'b1);
    check("b2b.addr0",  mem_addr_o[0], 32'h0000_0200);
    check("b2b.rv_t0",  d_rvalid_o[0], 1'b0);
    cyc();
    d_addr    = 32'h0000_0204;
    mem_rdata = 32'h1111_2222;
    mid();
    check("b2b.gnt1",   d_gnt_o[0],    1'b1);
    check("b2b.addr1",  mem_addr_o[0], 32'h0000_0204);
    check("b2b.rv1",    d_rvalid_o[0], 1'b1);
    check("b2b.rdata1", d_rdata_o[0],  32'h1111_2222);
    cyc();
    d_req     = 1'b0;
    mem_rdata = 32'h3333_4444;
    mid();
    check("b2b.gnt2",   d_gnt_o[0],    1'b0);
    check("b2b.rv2",    d_rvalid_o[0], 1'b1);
    check("b2b.rdata2", d_rdata_o[0],  32'h3333_4444);
    check("b2b.if_rv2", if_rvalid_o[0], 1'b0);
    cyc();
    mid();
    check("b2b.rv3", d_rvalid_o[0], 1'b0);
    drain(5);

    // ---- Contention, STARVE_MAX=4, RD_LAT=1: d,d,d,d,if,d,d,d,d,if ----
    begin
      logic [9:0] exp_if;
      logic       prev_valid;
      logic       prev_if;
      exp_if     = 10'b10000_10000;  // bit k = fetch expected in cycle k
      prev_valid = 1'b0;
      prev_if    = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h0000_0080;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0300;
      for (int k = 0; k < 10; k++) begin
        if (k != 0) cyc();
        mid();
        check($sformatf("starve.if_gnt[%0d]", k), if_gnt_o[0], exp_if[k]);
        check($sformatf("starve.d_gnt[%0d]", k),  d_gnt_o[0],  !exp_if[k]);
        check($sformatf("starve.if_rv[%0d]", k),  if_rvalid_o[0], prev_valid && prev_if);
        check($sformatf("starve.d_rv[%0d]", k),   d_rvalid_o[0],  prev_valid && !prev_if);
        prev_valid = 1'b1;
        prev_if    = exp_if[k];
      end
    end
    cyc();
    drain(8);

    // ---- Latency gating, RD_LAT=3 (instance 2) ----
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0400;
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    mid();
    check("lat3.d_gnt_T",  d_gnt_o[2],  1'b1);
    check("lat3.if_gnt_T", if_gnt_o[2], 1'b0);
    cyc();
    d_req = 1'b0;
    mid();
    check("lat3.if_gnt_T1", if_gnt_o[2], 1'b0);
    check("lat3.mem_en_T1", mem_en_o[2], 1'b0);
    cyc();
    mid();
    check("lat3.if_gnt_T2", if_gnt_o[2], 1'b0);
    check("lat3.d_rv_T2",   d_rvalid_o[2], 1'b0);
    cyc();
    mem_rdata = 32'h0000_D00D;
    mid();
    check("lat3.if_gnt_T3",   if_gnt_o[2],   1'b1);
    check("lat3.mem_addr_T3", mem_addr_o[2], 32'h0000_0040);
    check("lat3.d_rv_T3",     d_rvalid_o[2], 1'b1);
    check("lat3.d_rdata_T3",  d_rdata_o[2],  32'h0000_D00D);
    cyc();
    if_req = 1'b0;
    mid();
    check("lat3.if_rv_T4", if_rvalid_o[2], 1'b0);
    check("lat3.d_rv_T4",  d_rvalid_o[2],  1'b0);
    cyc();
    mid();
    check("lat3.if_rv_T5", if_rvalid_o[2], 1'b0);
    cyc();
    mem_rdata = 32'h0000_F00F;
    mid();
    check("lat3.if_rv_T6",    if_rvalid_o[2], 1'b1);
    check("lat3.if_rdata_T6", if_rdata_o[2],  32'h0000_F00F);
    check("lat3.d_rv_T6",     d_rvalid_o[2],  1'b0);
    drain(8);

    // ---- Reset mid-read, RD_LAT=2 (instance 1) ----
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    mid();
    check("rstrd.d_gnt", d_gnt_o[1], 1'b1);
    cyc();
    d_req = 1'b0;
    rst   = 1'b1;
    mid();
    check("rstrd.gnt_in_rst", d_gnt_o[1], 1'b0);
    cyc();
    rst = 1'b0;
    mid();
    check_quiet(1, "rstrd.after");
    cyc();
    mid();
    check("rstrd.no_late_rv", d_rvalid_o[1], 1'b0);
    cyc();
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    mid();
    check("rstrd.idle_gnt", if_gnt_o[1], 1'b1);
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
